tetris_key_cmd: RTL and testbench

//  Consumes the 8-bit USB HID keycode published by the Nios SoC keycode PIO.

---
 rtl/tetris_pkg.sv | 61 ++++++
 rtl/tetris_key_cmd_if.sv | 16 +
 rtl/key_repeat_timer.sv | 36 +++
 rtl/tetris_key_cmd.sv | 114 +++++++++++
 tb/tb_tetris_key_cmd.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared types and HID key decoding for the Tetris keyboard command path.
package tetris_pkg;

    typedef enum logic [2:0] {
        LEFT    = 3'd0,
        RIGHT   = 3'd1,
        ROT_CW  = 3'd2,
        ROT_CCW = 3'd3,
        SOFT    = 3'd4,
        HARD    = 3'd5,
        HOLD    = 3'd6,
        PAUSE   = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } state_e;

    // Decoded key: hit is low for 8'h00 and for any code without a command.
    typedef struct packed {
        logic hit;
        cmd_e cmd;
    } key_map_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_Z     = 8'h1D;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_C     = 8'h06;
    localparam logic [7:0] KEY_P     = 8'h13;

    function automatic key_map_t map_key(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.cmd = LEFT;
        case (code)
            KEY_A:     m.cmd = LEFT;
            KEY_D:     m.cmd = RIGHT;
            KEY_S:     m.cmd = SOFT;
            KEY_W:     m.cmd = ROT_CW;
            KEY_Z:     m.cmd = ROT_CCW;
            KEY_SPACE: m.cmd = HARD;
            KEY_C:     m.cmd = HOLD;
            KEY_P:     m.cmd = PAUSE;
            default:   m.hit = 1'b0;
        endcase
        return m;
    endfunction

    // Commands that keep firing while their key stays down.
    function automatic logic is_repeat(input cmd_e c);
        return (c == LEFT) || (c == RIGHT) || (c == SOFT);
    endfunction

endpackage

// File: rtl/tetris_key_cmd_if.sv
// Keycode in, move command out (valid/ready) between the SoC and the game FSM.
interface tetris_key_cmd_if;
    import tetris_pkg::*;

    logic [7:0] keycode;
    logic       cmd_valid;
    cmd_e       cmd_code;
    logic       cmd_ready;
    logic       key_active;

    // master: the command generator; slave: keycode source plus command consumer
    modport master (input keycode, input cmd_ready,
                    output cmd_valid, output cmd_code, output key_active);
    modport slave  (output keycode, output cmd_ready,
                    input cmd_valid, input cmd_code, input key_active);
endinterface

// File: rtl/key_repeat_timer.sv
// Down-counter for DAS / auto-repeat intervals; stops at zero instead of wrapping.
module key_repeat_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         run_i,
    output logic         expire_o
);

    logic [W-1:0] count_q, count_d;

    // Reload wins over counting down; an idle or expired counter holds its value.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (run_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = run_i && (count_q == '0);

endmodule

// File: rtl/tetris_key_cmd.sv
// Turns the held HID keycode into discrete Tetris commands with DAS/auto-repeat,
// offered through a single-entry valid/ready output register.
module tetris_key_cmd
    import tetris_pkg::*;
#(
    parameter int DAS_CYCLES = 8_333_333,
    parameter int ARR_CYCLES = 2_500_000,
    parameter int SDR_CYCLES = 1_250_000
) (
    input  logic             Clk,
    input  logic             Reset_h,
    tetris_key_cmd_if.master bus
);

    localparam int MAX_A = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int MAX_C = (MAX_A > SDR_CYCLES) ? MAX_A : SDR_CYCLES;
    localparam int TW    = (MAX_C > 2) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] DAS_LD = TW'(DAS_CYCLES - 1);
    localparam logic [TW-1:0] ARR_LD = TW'(ARR_CYCLES - 1);
    localparam logic [TW-1:0] SDR_LD = TW'(SDR_CYCLES - 1);

    logic [7:0]  key_q, cur_key_q, cur_key_d;
    state_e      state_q, state_d;
    logic        cmd_valid_q, cmd_valid_d;
    cmd_e        cmd_code_q, cmd_code_d;
    logic        key_active_q;
    key_map_t    km;
    logic        press_emit, rep_emit, accept, expire;
    logic        t_load;
    logic [TW-1:0] t_val;

    assign km     = map_key(key_q);
    assign accept = cmd_valid_q && bus.cmd_ready;

    key_repeat_timer #(.W(TW)) u_timer (
        .clk_i      (Clk),
        .rst_i      (Reset_h),
        .load_i     (t_load),
        .load_val_i (t_val),
        .run_i      ((state_q == ST_DELAY) || (state_q == ST_REPEAT)),
        .expire_o   (expire)
    );

    // FSM next state: release/unmapped returns to idle, a new key is a press, expiry is a repeat.
    always_comb begin
        state_d    = state_q;
        cur_key_d  = cur_key_q;
        press_emit = 1'b0;
        rep_emit   = 1'b0;
        t_load     = 1'b0;
        t_val      = '0;
        if (!km.hit) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                t_load  = 1'b1;
            end
        end else if ((state_q == ST_IDLE) || (key_q != cur_key_q)) begin
            press_emit = 1'b1;
            cur_key_d  = key_q;
            t_load     = 1'b1;
            if (km.cmd == SOFT) begin
                state_d = ST_REPEAT;
                t_val   = SDR_LD;
            end else if (is_repeat(km.cmd)) begin
                state_d = ST_DELAY;
                t_val   = DAS_LD;
            end else begin
                state_d = ST_HELD;
            end
        end else if (expire) begin
            rep_emit = 1'b1;
            state_d  = ST_REPEAT;
            t_load   = 1'b1;
            t_val    = (km.cmd == SOFT) ? SDR_LD : ARR_LD;
        end
    end

    // Output slot: presses always overwrite, repeats only land in a free or draining slot.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        if (press_emit || (rep_emit && (!cmd_valid_q || accept))) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = km.cmd;
        end else if (accept) begin
            cmd_valid_d = 1'b0;
        end
    end

    // State, input capture and output registers.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            key_q        <= KEY_NONE;
            cur_key_q    <= KEY_NONE;
            state_q      <= ST_IDLE;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= LEFT;
            key_active_q <= 1'b0;
        end else begin
            key_q        <= bus.keycode;
            cur_key_q    <= cur_key_d;
            state_q      <= state_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            key_active_q <= km.hit;
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_code   = cmd_code_q;
    assign bus.key_active = key_active_q;

endmodule

// File: tb/tb_tetris_key_cmd.sv
// Directed and randomized bench for tetris_key_cmd against a key-age based reference model.
module tb_tetris_key_cmd;

    localparam int DAS = 10;
    localparam int ARR = 4;
    localparam int SDR = 3;

    logic Clk;
    logic Reset_h;

    tetris_key_cmd_if bus();

    tetris_key_cmd #(
        .DAS_CYCLES (DAS),
        .ARR_CYCLES (ARR),
        .SDR_CYCLES (SDR)
    ) dut (
        .Clk     (Clk),
        .Reset_h (Reset_h),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;
    int ph_cnt = 0;

    // Reference model: the key seen by the DUT and how many cycles it has been held.
    logic [7:0] m_kq;
    int         m_age;
    logic       m_valid;
    logic [7:0] m_code;
    logic       m_active;

    // Command number in cmd_e order, or -1 for no command.
    function automatic int tb_map(input logic [7:0] k);
        case (k)
            8'h04: return 0;
            8'h07: return 1;
            8'h1A: return 2;
            8'h1D: return 3;
            8'h16: return 4;
            8'h2C: return 5;
            8'h06: return 6;
            8'h13: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [7:0] k, input logic r, input logic rs);
        int  c;
        logic emit, press, acc;
        if (rs) begin
            m_kq = 8'h00; m_age = 0; m_valid = 1'b0; m_code = 8'd0; m_active = 1'b0;
        end else begin
            c     = tb_map(m_kq);
            press = (m_age == 0);
            emit  = 1'b0;
            if (c == 0 || c == 1)
                emit = (m_age == 0) || (m_age >= DAS && ((m_age - DAS) % ARR) == 0);
            else if (c == 4)
                emit = ((m_age % SDR) == 0);
            else if (c >= 0)
                emit = (m_age == 0);
            acc = m_valid && r;
            if (emit && (press || !m_valid || acc)) begin
                m_valid = 1'b1;
                m_code  = 8'(c);
            end else if (acc) begin
                m_valid = 1'b0;
            end
            m_active = (c >= 0);
            if (tb_map(k) >= 0 && k == m_kq) m_age++;
            else m_age = 0;
            m_kq = k;
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic [7:0] k, input logic r, input logic rs);
        bus.keycode   = k;
        bus.cmd_ready = r;
        Reset_h       = rs;
        model_step(k, r, rs);
        @(posedge Clk);
        #1;
        chk("cmd_valid", {7'd0, bus.cmd_valid}, {7'd0, m_valid});
        chk("cmd_code", {5'd0, bus.cmd_code}, m_code);
        chk("key_active", {7'd0, bus.key_active}, {7'd0, m_active});
        if (bus.cmd_valid === 1'b1) ph_cnt++;
    endtask

    task automatic hold(input logic [7:0] k, input int n, input logic r);
        for (int i = 0; i < n; i++) step(k, r, 1'b0);
    endtask

    logic [7:0] pool [10] = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h1D, 8'h2C, 8'h06, 8'h13, 8'h55};

    initial begin
        bus.keycode = 8'h00; bus.cmd_ready = 1'b1; Reset_h = 1'b1;
        m_kq = 8'h00; m_age = 0; m_valid = 1'b0; m_code = 8'd0; m_active = 1'b0;

        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        chk("reset_valid", {7'd0, bus.cmd_valid}, 8'd0);
        chk("reset_code", {5'd0, bus.cmd_code}, 8'd0);
        hold(8'h00, 2, 1'b1);

        // Left held: press, DAS, then ARR repeats.
        ph_cnt = 0;
        hold(8'h04, 30, 1'b1);
        hold(8'h00, 5, 1'b1);
        chk("p1_left_count", 8'(ph_cnt), 8'd6);

        // One-shot rotate: one per press.
        ph_cnt = 0;
        hold(8'h1A, 50, 1'b1);
        hold(8'h00, 3, 1'b1);
        hold(8'h1A, 5, 1'b1);
        hold(8'h00, 3, 1'b1);
        chk("p2_rot_count", 8'(ph_cnt), 8'd2);

        // Soft drop repeats from press; unmapped key is silent.
        ph_cnt = 0;
        hold(8'h16, 12, 1'b1);
        hold(8'h00, 2, 1'b1);
        chk("p3_soft_count", 8'(ph_cnt), 8'd4);
        ph_cnt = 0;
        hold(8'h55, 5, 1'b1);
        chk("p3_unmapped_count", 8'(ph_cnt), 8'd0);
        chk("p3_unmapped_active", {7'd0, bus.key_active}, 8'd0);

        // Consumer stalled: latest press wins, single accept.
        step(8'h04, 1'b0, 1'b0);
        hold(8'h2C, 5, 1'b0);
        chk("p4_pending_valid", {7'd0, bus.cmd_valid}, 8'd1);
        chk("p4_pending_code", {5'd0, bus.cmd_code}, 8'd5);
        step(8'h2C, 1'b1, 1'b0);
        chk("p4_after_accept", {7'd0, bus.cmd_valid}, 8'd0);
        hold(8'h00, 3, 1'b1);

        // Direct right-to-left switch restarts DAS.
        ph_cnt = 0;
        hold(8'h07, 20, 1'b1);
        hold(8'h04, 15, 1'b1);
        hold(8'h00, 4, 1'b1);
        chk("p5_switch_count", 8'(ph_cnt), 8'd7);

        // Reset during repeat with key still held.
        hold(8'h07, 20, 1'b1);
        step(8'h07, 1'b1, 1'b1);
        chk("p6_reset_valid", {7'd0, bus.cmd_valid}, 8'd0);
        step(8'h07, 1'b1, 1'b0);
        step(8'h07, 1'b1, 1'b0);
        chk("p6_fresh_valid", {7'd0, bus.cmd_valid}, 8'd1);
        chk("p6_fresh_code", {5'd0, bus.cmd_code}, 8'd1);
        hold(8'h07, 3, 1'b1);
        hold(8'h00, 3, 1'b1);

        // Randomized key segments, back-pressure and occasional reset.
        for (int s = 0; s < 60; s++) begin
            logic [7:0] k;
            int len;
            k   = pool[$urandom_range(0, 9)];
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                step(k, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
